// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, word-organised IMEM.
// Optional fetch counter enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  localparam int         AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [63:0]   branch_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   Instruction,
  output logic [63:0]   PC_Out,
  output logic [63:0]   adder_out1,
  output logic          misaligned,
  output logic [31:0]   fetch_count
);

  logic [63:0] r_pc;
  logic        r_mis;
  logic [31:0] r_mem [IMEM_WORDS];

  logic [63:0] w_pc_inc;
  logic [63:0] w_next_pc;
  logic        w_adv;
  logic        w_bad_tgt;

  assign w_pc_inc  = r_pc + 64'd4;
  assign w_bad_tgt = branch_taken &&
                     (branch_target[1:0] != 2'b00);

  // Redirect outranks stall so a taken branch is never lost.
  always_comb begin
    w_next_pc = r_pc;
    w_adv     = 1'b0;
    priority case (1'b1)
      branch_taken: begin
        w_next_pc = {branch_target[63:2], 2'b00};
        w_adv     = 1'b1;
      end
      !stall: begin
        w_next_pc = w_pc_inc;
        w_adv     = 1'b1;
      end
      default: begin
        w_next_pc = r_pc;
        w_adv     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_mis <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_bad_tgt) begin
        r_mis <= 1'b1;
      end
    end
  end

  // Program memory survives reset; loads are only gated by it.
  always_ff @(posedge clk) begin
    if (reset && imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
  end

  assign Instruction = r_mem[r_pc[AW+1:2]];
  assign PC_Out      = r_pc;
  assign adder_out1  = w_pc_inc;
  assign misaligned  = r_mis;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
    end else if (w_adv && (r_fetch_cnt != '1)) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
`else
  logic w_adv_unused;
  assign w_adv_unused = w_adv;
  assign fetch_count  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage.
// Expected state comes from a behavioural PC/IMEM model.
module tb_if_fetch_stage;
  localparam int          W   = 64;
  localparam int          AW  = 6;
  localparam logic [63:0] RPC = 64'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [63:0]   branch_target = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic [31:0]   Instruction;
  logic [63:0]   PC_Out;
  logic [63:0]   adder_out1;
  logic          misaligned;
  logic [31:0]   fetch_count;

  if_fetch_stage #(
    .IMEM_WORDS(W),
    .RESET_PC  (RPC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .Instruction  (Instruction),
    .PC_Out       (PC_Out),
    .adder_out1   (adder_out1),
    .misaligned   (misaligned),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] add;
    logic [31:0] ins;
    logic        vld;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [W];
  bit          m_vld [W];
  logic [63:0] m_pc  = RPC;
  logic        m_mis = 1'b0;
  logic [31:0] m_cnt = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(string tag, logic [63:0] act,
                     logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    logic [AW-1:0] ix;
    ix    = m_pc[AW+1:2];
    e.pc  = m_pc;
    e.add = m_pc + 64'd4;
    e.ins = m_mem[ix];
    e.vld = m_vld[ix];
    e.mis = m_mis;
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic cmp(exp_t e);
    chk("pc", PC_Out, e.pc);
    chk("adder", adder_out1, e.add);
    if (e.vld) chk("instr", {32'h0, Instruction},
                   {32'h0, e.ins});
    chk("mis", {63'h0, misaligned}, {63'h0, e.mis});
    chk("cnt", {32'h0, fetch_count}, {32'h0, e.cnt});
  endtask

  task automatic cyc(bit rst, bit st, bit br,
                     logic [63:0] tgt, bit we = 1'b0,
                     logic [AW-1:0] wa = '0,
                     logic [31:0] wd = '0);
    reset = rst;
    stall = st;
    branch_taken = br;
    branch_target = tgt;
    imem_we = we;
    imem_waddr = wa;
    imem_wdata = wd;
    if (!rst) begin
      m_pc  = RPC;
      m_mis = 1'b0;
      m_cnt = '0;
    end else begin
      if (we) begin
        m_mem[wa] = wd;
        m_vld[wa] = 1'b1;
      end
      if (br && tgt[1:0] != 2'b00) m_mis = 1'b1;
`ifdef IF_FETCH_PERF_CNT_EN
      if ((br || !st) && m_cnt != 32'hFFFF_FFFF)
        m_cnt = m_cnt + 32'd1;
`endif
      if (br) m_pc = {tgt[63:2], 2'b00};
      else if (!st) m_pc = m_pc + 64'd4;
    end
    q.push_back(snap());
    @(posedge clk);
    #1;
    cmp(q.pop_front());
  endtask

  task automatic adv(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0);
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] base;
    logic [AW-1:0] ix;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193;
    for (int i = 0; i < W; i++) m_vld[i] = 1'b0;

    #3;
    cmp(snap());

    for (int i = 0; i < W; i++) begin
      cyc(1, 1, 0, '0, 1, AW'(i),
          (i < 4) ? prog[i] : 32'hC0DE_0000 + i);
    end
    chk("c0_pc", PC_Out, 64'h0);
    chk("c0_ins", {32'h0, Instruction}, 64'h13);

    adv(2);
    cyc(1, 1, 0, '0);
    cyc(1, 1, 0, '0);
    chk("stall_pc", PC_Out, 64'h8);
    chk("stall_ins", {32'h0, Instruction}, 64'h0020_0113);
    adv(1);
    chk("pc12", PC_Out, 64'd12);
    chk("add16", adder_out1, 64'd16);
    chk("ins12", {32'h0, Instruction}, 64'h0030_0193);

    base = m_cnt;
    adv(5);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);
    cyc(1, 1, 1, 64'h20);
    chk("br20", PC_Out, 64'h20);
    chk("mis0", {63'h0, misaligned}, 64'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("perf6", {32'h0, fetch_count},
        {32'h0, base + 32'd6});
`else
    chk("perf0", {32'h0, fetch_count}, 64'h0);
`endif

    cyc(1, 0, 1, 64'h46);
    chk("br44", PC_Out, 64'h44);
    chk("mis1", {63'h0, misaligned}, 64'h1);
    adv(10);
    chk("mis_sticky", {63'h0, misaligned}, 64'h1);

    cyc(1, 0, 1, 64'h44);
    stall = 1'b1;
    branch_taken = 1'b0;
    ix = m_pc[AW+1:2];
    imem_we = 1'b1;
    imem_waddr = ix;
    imem_wdata = 32'h1234_5678;
    #1;
    chk("rdw_old", {32'h0, Instruction},
        {32'h0, m_mem[ix]});
    cyc(1, 1, 0, '0, 1, ix, 32'h1234_5678);
    chk("rdw_new", {32'h0, Instruction}, 64'h1234_5678);

    cyc(1, 0, 1, 64'hF0);
    adv(4);
    chk("pc100", PC_Out, 64'h100);
    chk("wrap_ins", {32'h0, Instruction}, 64'h13);

    cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("add_wrap", adder_out1, 64'h0);
    adv(1);
    chk("pc_wrap", PC_Out, 64'h0);

    cyc(1, 0, 1, 64'h2E);
    adv(1);
    chk("pc30", PC_Out, 64'h30);
    #2;
    reset = 1'b0;
    m_pc  = RPC;
    m_mis = 1'b0;
    m_cnt = '0;
    #1;
    chk("arst_pc", PC_Out, RPC);
    chk("arst_mis", {63'h0, misaligned}, 64'h0);
    chk("arst_cnt", {32'h0, fetch_count}, 64'h0);
    cmp(snap());
    cyc(0, 0, 0, '0, 1, '0, 32'hFFFF_FFFF);
    cyc(1, 0, 0, '0);
    chk("first_adv", PC_Out, RPC + 64'd4);
    cyc(1, 0, 1, 64'h0);
    chk("mem_kept", {32'h0, Instruction}, 64'h13);

    for (int i = 0; i < 60; i++) begin
      cyc(1, ($urandom % 3) == 0, ($urandom % 5) == 0,
          {$urandom, $urandom},
          ($urandom % 4) == 0,
          AW'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 64-bit RISC-V pipelined core, sitting directly upstream of the IF/ID pipeline register. It holds the program counter and computes PC+4. It reads a 32-bit instruction from a word-organised instruction memory and drives `Instruction`, `PC_Out` and `adder_out1` into IF/ID. It honours the hazard unit's stall and the branch unit's redirect.

## Interface
Parameters:
- `IMEM_WORDS`, 64: instruction memory depth in 32-bit words; power of two, ≥ 4; `AW = log2(IMEM_WORDS)`.
- `RESET_PC`, 64'h0: PC value loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it low immediately clears all state.
- `stall`  in  1  hazard-unit stall; holds PC.
- `branch_taken`  in  1  redirect request from the branch unit.
- `branch_target`  in  64  redirect byte address.
- `imem_we`  in  1  program-load write enable.
- `imem_waddr`  in  AW  word address for the load.
- `imem_wdata`  in  32  instruction word to load.
- `Instruction`  out  32  `mem[PC_Out[AW+1:2]]`.
- `PC_Out`  out  64  current PC.
- `adder_out1`  out  64  `PC_Out + 4`, modulo 2^64.
- `misaligned`  out  1  sticky flag: a redirect target had nonzero bits [1:0].
- `fetch_count`  out  32  count of PC advances; see Configuration.

## Operation
- Next-PC priority, highest first:
  - `reset` low: `PC = RESET_PC`.
  - `branch_taken`: `PC = {branch_target[63:2], 2'b00}`. This wins over `stall`.
  - `stall`: PC holds.
  - Otherwise: `PC = PC + 4`.
- PC is always word-aligned; bits [1:0] are constant 0.
- Memory read is combinational. The index is `PC_Out[AW+1:2]`, so any PC beyond the memory range wraps modulo `IMEM_WORDS*4`. There is no out-of-range fault.
- Memory write is synchronous. When `imem_we` is high at a rising edge and `reset` is high, `mem[imem_waddr] = imem_wdata`.
  - Writes are independent of `stall` and `branch_taken`.
  - Writes are ignored while `reset` is low.
  - Memory contents are not cleared by reset.
- Read-during-write to the word currently addressed by PC: `Instruction` shows the old word until the edge, and the new word after it.
- `misaligned` is set on any edge where `branch_taken` is high and `branch_target[1:0] != 0`. It stays set until reset.
- Reset values: `PC_Out = RESET_PC`, `adder_out1 = RESET_PC + 4`, `Instruction = mem[RESET_PC[AW+1:2]]`, `misaligned = 0`, `fetch_count = 0`.
- Reset asserted mid-operation: PC, flag and counter clear asynchronously without waiting for an edge. The first advance occurs on the first rising edge after `reset` returns high.

## Timing
- `PC_Out`, `adder_out1` and `Instruction` are valid in the same cycle the PC register updates. IF/ID captures them on the following edge, so there is one cycle from PC update to IF/ID output.
- Redirect: with `branch_taken` high in cycle n, `PC_Out = target` in cycle n+1. No bubble is inserted in this block; squashing the wrong-path instruction is the downstream flush logic's job.
- Stall: with `stall` high in cycle n and no redirect, all outputs in cycle n+1 equal those in cycle n.
- The PC adder wraps: `PC = 64'hFFFF_FFFF_FFFF_FFFC` advances to 0.

## Configuration
- `IF_FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every edge where the PC changes source to redirect or +4, i.e. any edge with `reset` high and (`branch_taken` or not `stall`).
  - It saturates at 32'hFFFF_FFFF.
- Undefined: the counter logic is not compiled and `fetch_count` is tied to 0. The port list is unchanged.

## Test plan
- Reset low with `RESET_PC=0`, preload `mem[0..3]=0x00000013,0x00100093,0x00200113,0x00300193`, release reset -> cycle 0 `PC_Out=0`, `Instruction=0x00000013`; after 3 edges `PC_Out=12`, `adder_out1=16`, `Instruction=0x00300193`.
- `stall` high for 2 edges at `PC=8` -> `PC_Out` stays 8, `Instruction` stays `0x00200113`; next edge with `stall` low -> `PC_Out=12`.
- `stall=1` and `branch_taken=1` with `branch_target=0x20` on the same edge -> `PC_Out=0x20`, `misaligned=0`; then `branch_target=0x46` -> `PC_Out=0x44`, `misaligned=1`, still set 10 cycles later.
- `IMEM_WORDS=64`, PC reaches 0xFC then advances -> `PC_Out=0x100`, `Instruction=mem[0]` (wrap); `PC=64'hFFFF_FFFF_FFFF_FFFC` +4 -> `PC_Out=0`.
- Reset pulled low between edges mid-run at `PC=0x30` -> `PC_Out=RESET_PC` immediately with no clock edge, `misaligned=0`, `fetch_count=0`; memory contents unchanged.
- With `IF_FETCH_PERF_CNT_EN` defined: 5 advances, 3 stalls, 1 redirect-during-stall -> `fetch_count=6`. Undefined -> `fetch_count=0` throughout.
